// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: one digit per PRESCALE-cycle slot, frame-coherent
// data snapshot, per-slot anti-ghosting guard, leading-zero blanking and selectable polarity.
module seven_seg_scan_ctrl #(
  parameter int N_DIGITS   = 4,
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 2,
  parameter int HEX_MODE   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [4*N_DIGITS-1:0] D,
  input  logic [N_DIGITS-1:0]   DP_IN,
  input  logic                  LZ_BLANK,
  output logic [6:0]            SevOut,
  output logic                  DP,
  output logic [N_DIGITS-1:0]   Dig,
  output logic                  Frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic          INACT    = (ACTIVE_LOW != 0);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] snap_d;
  logic [N_DIGITS-1:0]   snap_dp;

  logic                  slot_end;
  logic                  frame_end;
  logic                  in_guard;
  logic [3:0]            code;
  logic                  dp_req;
  logic                  blank;
  logic                  upper_zero;
  logic [N_DIGITS-1:0]   lz_vec;
  logic [N_DIGITS-1:0]   onehot;
  logic [6:0]            seg_al;

  // Segment patterns in active-low form ({g,f,e,d,c,b,a}, 0 = lit).
  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
      4'hB: s = (HEX_MODE != 0) ? 7'b0000011 : 7'b1111111;
      4'hC: s = (HEX_MODE != 0) ? 7'b1000110 : 7'b1111111;
      4'hD: s = (HEX_MODE != 0) ? 7'b0100001 : 7'b1111111;
      4'hE: s = (HEX_MODE != 0) ? 7'b0000110 : 7'b1111111;
      default: s = (HEX_MODE != 0) ? 7'b0001110 : 7'b1111111;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign in_guard  = (GUARD != 0) && (cnt < GUARD_C);

  // Walk from the most significant digit down; a digit is a leading zero while all above are zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_vec     = '0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      upper_zero = upper_zero && (snap_d[4*(N_DIGITS-1-j) +: 4] == 4'd0);
      lz_vec[N_DIGITS-1-j] = upper_zero && ((N_DIGITS - 1 - j) != 0);
    end
  end

  always_comb begin
    code   = '0;
    dp_req = 1'b0;
    blank  = 1'b0;
    onehot = '0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (idx == IW'(j)) begin
        code      = snap_d[4*j +: 4];
        dp_req    = snap_dp[j];
        blank     = LZ_BLANK && lz_vec[j];
        onehot[j] = 1'b1;
      end
    end
    seg_al = blank ? 7'b1111111 : decode(code);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      idx        <= '0;
      snap_d     <= '0;
      snap_dp    <= '0;
      Dig        <= {N_DIGITS{INACT}};
      SevOut     <= {7{INACT}};
      DP         <= INACT;
      Frame_tick <= 1'b0;
    end else begin
      Frame_tick <= EN && frame_end;
      if (EN) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (frame_end) begin
          snap_d  <= D;
          snap_dp <= DP_IN;
        end
      end
      if (!EN || in_guard) begin
        Dig    <= {N_DIGITS{INACT}};
        SevOut <= {7{INACT}};
        DP     <= INACT;
      end else begin
        Dig    <= onehot ^ {N_DIGITS{INACT}};
        SevOut <= seg_al ^ {7{~INACT}};
        DP     <= dp_req ^ INACT;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: scan order, snapshot coherence, blanking, hex,
// polarity, enable freeze and asynchronous reset, using three parameter variants.
module tb_seven_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [15:0] D;
  logic [3:0]  DP_IN;
  logic        LZ_BLANK;

  logic [6:0] seg,    seg_h0,    seg_ah;
  logic       dp,     dp_h0,     dp_ah;
  logic [3:0] dig,    dig_h0,    dig_ah;
  logic       ft,     ft_h0,     ft_ah;

  int checks = 0;
  int errors = 0;

  logic [3:0] c_dig[16], c_dig_h0[16], c_dig_ah[16];
  logic [6:0] c_seg[16], c_seg_h0[16], c_seg_ah[16];
  logic       c_dp[16],  c_dp_h0[16],  c_dp_ah[16];
  logic       c_ft[16],  c_ft_h0[16],  c_ft_ah[16];

  always #5 CLK = ~CLK;

  seven_seg_scan_ctrl #(.N_DIGITS(4), .PRESCALE(4), .GUARD(1), .HEX_MODE(1), .ACTIVE_LOW(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .DP_IN(DP_IN), .LZ_BLANK(LZ_BLANK),
    .SevOut(seg), .DP(dp), .Dig(dig), .Frame_tick(ft));

  seven_seg_scan_ctrl #(.N_DIGITS(4), .PRESCALE(4), .GUARD(1), .HEX_MODE(0), .ACTIVE_LOW(1)) dut_h0 (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .DP_IN(DP_IN), .LZ_BLANK(LZ_BLANK),
    .SevOut(seg_h0), .DP(dp_h0), .Dig(dig_h0), .Frame_tick(ft_h0));

  seven_seg_scan_ctrl #(.N_DIGITS(4), .PRESCALE(4), .GUARD(1), .HEX_MODE(1), .ACTIVE_LOW(0)) dut_ah (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .DP_IN(DP_IN), .LZ_BLANK(LZ_BLANK),
    .SevOut(seg_ah), .DP(dp_ah), .Dig(dig_ah), .Frame_tick(ft_ah));

  // Records 16 cycles; index k is the k+1-th edge after the frame tick. Optionally changes D mid-frame.
  task automatic capture_frame(input int change_at, input logic [15:0] new_d);
    for (int k = 0; k < 16; k++) begin
      @(posedge CLK); #1;
      c_dig[k] = dig;    c_seg[k] = seg;    c_dp[k] = dp;    c_ft[k] = ft;
      c_dig_h0[k] = dig_h0; c_seg_h0[k] = seg_h0; c_dp_h0[k] = dp_h0; c_ft_h0[k] = ft_h0;
      c_dig_ah[k] = dig_ah; c_seg_ah[k] = seg_ah; c_dp_ah[k] = dp_ah; c_ft_ah[k] = ft_ah;
      if (k + 1 == change_at) D = new_d;
    end
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (ft !== 1'b1 && n < 40);
    checks++;
    if (ft !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_tick timeout got=%b want=1", name, ft);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; EN = 1'b1; D = 16'h1234; DP_IN = 4'b0000; LZ_BLANK = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (dig !== 4'b1111) begin errors++; $display("FAIL reset_dig got=%b want=1111", dig); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b want=1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b want=1", dp); end
    checks++; if (ft !== 1'b0) begin errors++; $display("FAIL reset_ft got=%b want=0", ft); end
    checks++; if (dig_ah !== 4'b0000) begin errors++; $display("FAIL reset_dig_ah got=%b want=0000", dig_ah); end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (dig !== 4'b1111) begin errors++; $display("FAIL reset_guard_dig got=%b want=1111", dig); end
    @(posedge CLK); #1;
    checks++; if (dig !== 4'b1110) begin errors++; $display("FAIL reset_d0_dig got=%b want=1110", dig); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_d0_seg got=%b want=1000000", seg); end
  endtask

  task automatic test_scan;
    logic [6:0] g[4];
    logic [3:0] one;
    g[0] = 7'b0011001; g[1] = 7'b0110000; g[2] = 7'b0100100; g[3] = 7'b1111001;
    wait_frame("scan_first");
    capture_frame(0, 16'h0);
    for (int k = 0; k < 16; k++) begin
      one = 4'b0001 << (k / 4);
      checks++;
      if (c_dig[k] !== ((k % 4 == 0) ? 4'b1111 : ~one)) begin
        errors++; $display("FAIL scan_dig k=%0d got=%b want=%b", k, c_dig[k], (k % 4 == 0) ? 4'b1111 : ~one);
      end
      checks++;
      if (c_seg[k] !== ((k % 4 == 0) ? 7'b1111111 : g[k/4])) begin
        errors++; $display("FAIL scan_seg k=%0d got=%b want=%b", k, c_seg[k], (k % 4 == 0) ? 7'b1111111 : g[k/4]);
      end
      checks++;
      if (c_ft[k] !== (k == 15)) begin
        errors++; $display("FAIL scan_ft k=%0d got=%b want=%b", k, c_ft[k], (k == 15));
      end
    end
  endtask

  task automatic test_coherence;
    logic [6:0] g_old[4], g_new[4];
    g_old[0] = 7'b0011001; g_old[1] = 7'b0110000; g_old[2] = 7'b0100100; g_old[3] = 7'b1111001;
    g_new[0] = 7'b0000000; g_new[1] = 7'b1111000; g_new[2] = 7'b0000010; g_new[3] = 7'b0010010;
    capture_frame(6, 16'h5678);
    for (int k = 1; k < 16; k++) begin
      if (k % 4 != 0) begin
        checks++;
        if (c_seg[k] !== g_old[k/4]) begin
          errors++; $display("FAIL coh_old_seg k=%0d got=%b want=%b", k, c_seg[k], g_old[k/4]);
        end
      end
    end
    capture_frame(0, 16'h0);
    for (int k = 1; k < 16; k++) begin
      if (k % 4 != 0) begin
        checks++;
        if (c_seg[k] !== g_new[k/4]) begin
          errors++; $display("FAIL coh_new_seg k=%0d got=%b want=%b", k, c_seg[k], g_new[k/4]);
        end
      end
    end
  endtask

  task automatic test_lz_blank;
    logic [6:0] g_lz[4], g_on[4];
    g_lz[0] = 7'b1000000; g_lz[1] = 7'b0011001; g_lz[2] = 7'b1111111; g_lz[3] = 7'b1111111;
    g_on[0] = 7'b1000000; g_on[1] = 7'b0011001; g_on[2] = 7'b1000000; g_on[3] = 7'b1000000;
    D = 16'h0040; DP_IN = 4'b1000; LZ_BLANK = 1'b1;
    capture_frame(0, 16'h0);
    capture_frame(0, 16'h0);
    for (int k = 1; k < 16; k++) begin
      if (k % 4 != 0) begin
        checks++;
        if (c_seg[k] !== g_lz[k/4]) begin
          errors++; $display("FAIL lz_seg k=%0d got=%b want=%b", k, c_seg[k], g_lz[k/4]);
        end
        checks++;
        if (c_dp[k] !== (k / 4 != 3)) begin
          errors++; $display("FAIL lz_dp k=%0d got=%b want=%b", k, c_dp[k], (k / 4 != 3));
        end
      end
    end
    checks++;
    if (c_dig[14] !== 4'b0111) begin errors++; $display("FAIL lz_dig3 got=%b want=0111", c_dig[14]); end
    LZ_BLANK = 1'b0;
    capture_frame(0, 16'h0);
    for (int k = 1; k < 16; k++) begin
      if (k % 4 != 0) begin
        checks++;
        if (c_seg[k] !== g_on[k/4]) begin
          errors++; $display("FAIL lz_off_seg k=%0d got=%b want=%b", k, c_seg[k], g_on[k/4]);
        end
      end
    end
  endtask

  task automatic test_hex;
    logic [6:0] g[4];
    g[0] = 7'b0100001; g[1] = 7'b1000110; g[2] = 7'b0000011; g[3] = 7'b0001000;
    D = 16'hABCD; DP_IN = 4'b0000; LZ_BLANK = 1'b0;
    capture_frame(0, 16'h0);
    capture_frame(0, 16'h0);
    for (int k = 1; k < 16; k++) begin
      if (k % 4 != 0) begin
        checks++;
        if (c_seg[k] !== g[k/4]) begin
          errors++; $display("FAIL hex_seg k=%0d got=%b want=%b", k, c_seg[k], g[k/4]);
        end
        checks++;
        if (c_seg_h0[k] !== 7'b1111111) begin
          errors++; $display("FAIL hex0_seg k=%0d got=%b want=1111111", k, c_seg_h0[k]);
        end
      end
    end
    checks++;
    if (c_dig_h0[5] !== 4'b1101) begin errors++; $display("FAIL hex0_dig got=%b want=1101", c_dig_h0[5]); end
    checks++;
    if (c_dp_h0[5] !== 1'b1) begin errors++; $display("FAIL hex0_dp got=%b want=1", c_dp_h0[5]); end
    checks++;
    if (c_ft_h0[15] !== 1'b1) begin errors++; $display("FAIL hex0_ft got=%b want=1", c_ft_h0[15]); end
  endtask

  task automatic test_polarity;
    D = 16'h0008; DP_IN = 4'b0000;
    capture_frame(0, 16'h0);
    capture_frame(0, 16'h0);
    checks++;
    if (c_dig_ah[0] !== 4'b0000) begin errors++; $display("FAIL pol_guard_dig got=%b want=0000", c_dig_ah[0]); end
    checks++;
    if (c_seg_ah[0] !== 7'b0000000) begin errors++; $display("FAIL pol_guard_seg got=%b want=0000000", c_seg_ah[0]); end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (c_dig_ah[k] !== 4'b0001) begin errors++; $display("FAIL pol_dig k=%0d got=%b want=0001", k, c_dig_ah[k]); end
      checks++;
      if (c_seg_ah[k] !== 7'b1111111) begin errors++; $display("FAIL pol_seg k=%0d got=%b want=1111111", k, c_seg_ah[k]); end
      checks++;
      if (c_dp_ah[k] !== 1'b0) begin errors++; $display("FAIL pol_dp k=%0d got=%b want=0", k, c_dp_ah[k]); end
    end
    checks++;
    if (c_seg_ah[5] !== 7'b0111111) begin errors++; $display("FAIL pol_d1_seg got=%b want=0111111", c_seg_ah[5]); end
    checks++;
    if (c_ft_ah[15] !== 1'b1) begin errors++; $display("FAIL pol_ft got=%b want=1", c_ft_ah[15]); end
  endtask

  // Entered right at a frame tick with snapshot 0x0008 showing.
  task automatic test_enable;
    logic [3:0] want_dig[4];
    want_dig[0] = 4'b1101; want_dig[1] = 4'b1101; want_dig[2] = 4'b1111; want_dig[3] = 4'b1011;
    repeat (6) @(posedge CLK);
    #1;
    EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK); #1;
      checks++;
      if (dig !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || ft !== 1'b0) begin
        errors++; $display("FAIL en_off k=%0d got dig=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0", k, dig, seg, dp, ft);
      end
    end
    EN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      checks++;
      if (dig !== want_dig[k]) begin
        errors++; $display("FAIL en_resume_dig k=%0d got=%b want=%b", k, dig, want_dig[k]);
      end
      if (k != 2) begin
        checks++;
        if (seg !== 7'b1000000) begin
          errors++; $display("FAIL en_resume_seg k=%0d got=%b want=1000000", k, seg);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    wait_frame("areset_wait");
    #2;
    RST = 1'b1;
    #1;
    checks++; if (dig !== 4'b1111) begin errors++; $display("FAIL areset_dig got=%b want=1111", dig); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL areset_seg got=%b want=1111111", seg); end
    checks++; if (ft !== 1'b0) begin errors++; $display("FAIL areset_ft got=%b want=0", ft); end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (dig !== 4'b1111) begin errors++; $display("FAIL areset_guard got=%b want=1111", dig); end
    @(posedge CLK); #1;
    checks++; if (dig !== 4'b1110) begin errors++; $display("FAIL areset_d0_dig got=%b want=1110", dig); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL areset_d0_seg got=%b want=1000000", seg); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_coherence;
    test_lz_blank;
    test_hex;
    test_polarity;
    test_enable;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
